// File: rtl/free_list_allocator.sv
`default_nettype none
// ============================================================================
// Module   : free_list_allocator
// Purpose  : Free-slot tracker handing out the lowest free slot on a val/rdy
//            port; slots return through a one-cycle free port with error flag.
// Revision : 1.0 - initial release
// ============================================================================
module free_list_allocator #(
    parameter  int p_entries = 8,
    localparam int IW        = (p_entries > 1) ? $clog2(p_entries) : 1,
    localparam int CW        = $clog2(p_entries + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 alloc_val,
    input  logic                 alloc_rdy,
    output logic [p_entries-1:0] alloc_onehot,
    output logic [IW-1:0]        alloc_idx,
    input  logic                 free_val,
    input  logic [IW-1:0]        free_idx,
    output logic                 free_err,
    output logic [CW-1:0]        num_free
);

    localparam int c_ext_w = 2 ** IW;

    logic [p_entries-1:0] free_vec_q, free_vec_d;
    logic [CW-1:0]        num_free_q, num_free_d;
    logic                 free_err_q, free_err_d;

    logic [p_entries-1:0] w_onehot;
    logic [IW-1:0]        w_idx;
    logic                 w_fire;
    logic                 w_in_range;
    logic                 w_legal;
    logic [c_ext_w-1:0]   w_vec_ext;
    logic [c_ext_w-1:0]   w_ret_mask;

    // Lowest set bit isolates the priority-encoder grant.
    assign w_onehot = free_vec_q & (~free_vec_q + p_entries'(1));

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < p_entries; i++) begin
            if (w_onehot[i]) begin
                w_idx = w_idx | IW'(i);
            end
        end
    end

    // Index space is padded to 2**IW so out-of-range indices never address past the vector.
    always_comb begin
        w_vec_ext                  = '0;
        w_vec_ext[p_entries-1:0]   = free_vec_q;
        w_ret_mask                 = '0;
        w_ret_mask[free_idx]       = 1'b1;
    end

    assign w_fire     = (|free_vec_q) && alloc_rdy;
    assign w_in_range = (32'(free_idx) < p_entries);
    assign w_legal    = free_val && w_in_range && !w_vec_ext[free_idx];

    always_comb begin
        free_vec_d = free_vec_q;
        if (w_fire) begin
            free_vec_d = free_vec_d & ~w_onehot;
        end
        if (w_legal) begin
            free_vec_d = free_vec_d | w_ret_mask[p_entries-1:0];
        end
        num_free_d = num_free_q - CW'(w_fire) + CW'(w_legal);
        free_err_d = free_val && !w_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_vec_q <= '1;
            num_free_q <= CW'(p_entries);
            free_err_q <= 1'b0;
        end else begin
            free_vec_q <= free_vec_d;
            num_free_q <= num_free_d;
            free_err_q <= free_err_d;
        end
    end

    assign alloc_val    = |free_vec_q;
    assign alloc_onehot = w_onehot;
    assign alloc_idx    = w_idx;
    assign free_err     = free_err_q;
    assign num_free     = num_free_q;

endmodule
`default_nettype wire
